// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one pipelined fpMultiply32 among NREQ requesters. One operation is
//   issued per non-stalled clock. A {valid,id,tag} pipe, advanced in lockstep
//   with the multiplier clock enable, pairs each multiplier result with the
//   requester and user tag that issued it.
//
// Configuration macro:
//   FPMUL_ARB_RR_EN  defined   -> round-robin arbitration starting at r_rr
//                    undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             freezes issue, tag pipe and multiplier (mul_ce=0)
//   req_vld/req_rdy   per-requester valid / accept (one-hot accept)
//   req_a/b/tag       packed operands and tags, requester i at slice i
//   mul_ce/a/b        drive the shared multiplier
//   mul_o/ovf/unf     multiplier result and flags
//   res_*             result pulse with requester id and tag
//   inflight, idle    number of outstanding operations, inflight==0
module fp_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 15,
  parameter int TAGW = 4,
  parameter int OW   = 58,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 mul_ce,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [OW-1:0]        mul_o,
  input  logic                 mul_ovf,
  input  logic                 mul_unf,
  output logic                 res_vld,
  output logic [IDW-1:0]       res_id,
  output logic [TAGW-1:0]      res_tag,
  output logic [OW-1:0]        res_o,
  output logic                 res_ovf,
  output logic                 res_unf,
  output logic [CW-1:0]        inflight,
  output logic                 idle
);

  logic [IDW-1:0]  w_start;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW:0]    w_scan;
  logic [NREQ-1:0] w_grant;
  logic [TAGW-1:0] w_gnt_tag;
  logic            w_issue;
  logic            w_ret;

  logic            r_v   [LAT];
  logic [IDW-1:0]  r_id  [LAT];
  logic [TAGW-1:0] r_tag [LAT];
  logic [CW-1:0]   r_inflight;

`ifdef FPMUL_ARB_RR_EN
  logic [IDW-1:0]  r_rr;
  assign w_start = r_rr;
`else
  assign w_start = '0;
`endif

  // Search upward from w_start with wrap; first valid requester wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, w_start} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NREQ))
        w_scan = w_scan - (IDW+1)'(NREQ);
      if (!w_gnt_vld && req_vld[w_scan[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan[IDW-1:0];
      end
    end
  end

  assign w_grant = w_gnt_vld ? (NREQ'(1) << w_gnt_idx) : '0;
  // rst_n gating keeps req_rdy low while the block is held in reset.
  assign req_rdy = w_grant & {NREQ{~stall & rst_n}};
  assign w_issue = w_gnt_vld & ~stall & rst_n;
  assign mul_ce  = ~stall;

  // Operand/tag mux; with no grant a 0*0 bubble is sent and never tracked.
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    w_gnt_tag = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt_vld && (w_gnt_idx == IDW'(k))) begin
        mul_a     = req_a[32*k +: 32];
        mul_b     = req_b[32*k +: 32];
        w_gnt_tag = req_tag[TAGW*k +: TAGW];
      end
    end
  end

  // Issue -> tag pipe stage 0; stages advance only on enabled clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) r_v[s] <= 1'b0;
      r_inflight <= '0;
`ifdef FPMUL_ARB_RR_EN
      r_rr       <= '0;
`endif
    end else if (!stall) begin
      r_v[0] <= w_issue;
      for (int s = 1; s < LAT; s++) r_v[s] <= r_v[s-1];
      if (w_issue && !w_ret)
        r_inflight <= r_inflight + 1'b1;
      else if (!w_issue && w_ret)
        r_inflight <= r_inflight - 1'b1;
`ifdef FPMUL_ARB_RR_EN
      if (w_issue)
        r_rr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      r_id[0]  <= w_gnt_idx;
      r_tag[0] <= w_gnt_tag;
      for (int s = 1; s < LAT; s++) begin
        r_id[s]  <= r_id[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Last stage lines up with the multiplier output.
  assign w_ret    = r_v[LAT-1] & ~stall;
  assign res_vld  = w_ret;
  assign res_id   = r_id[LAT-1];
  assign res_tag  = r_tag[LAT-1];
  assign res_o    = mul_o;
  assign res_ovf  = mul_ovf;
  assign res_unf  = mul_unf;
  assign inflight = r_inflight;
  assign idle     = (r_inflight == '0);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed table of single transactions plus
// sequences for arbitration order, stall, mid-flight reset and steady state.
module tb_fp_mul_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 15;
  localparam int TAGW = 4;
  localparam int OW   = 58;

  logic                 clk = 1'b0;
  logic                 rst_n, stall;
  logic [NREQ-1:0]      req_vld, req_rdy;
  logic [NREQ*32-1:0]   req_a, req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 mul_ce;
  logic [31:0]          mul_a, mul_b;
  logic [OW-1:0]        mul_o;
  logic                 mul_ovf, mul_unf;
  logic                 res_vld;
  logic [1:0]           res_id;
  logic [TAGW-1:0]      res_tag;
  logic [OW-1:0]        res_o;
  logic                 res_ovf, res_unf;
  logic [3:0]           inflight;
  logic                 idle;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b),
    .mul_o(mul_o), .mul_ovf(mul_ovf), .mul_unf(mul_unf),
    .res_vld(res_vld), .res_id(res_id), .res_tag(res_tag),
    .res_o(res_o), .res_ovf(res_ovf), .res_unf(res_unf),
    .inflight(inflight), .idle(idle)
  );

  // Multiplier stand-in: LAT-deep enabled pipe returning {a, b[25:0]},
  // overflow = a[0], underflow = b[0], so each result identifies its operands.
  logic [63:0] s_pipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      s_pipe[0] <= {mul_a, mul_b};
      for (int s = 1; s < LAT; s++) s_pipe[s] <= s_pipe[s-1];
    end
  end
  assign mul_o   = {s_pipe[LAT-1][63:32], s_pipe[LAT-1][25:0]};
  assign mul_ovf = s_pipe[LAT-1][32];
  assign mul_unf = s_pipe[LAT-1][0];

  typedef struct {
    logic [1:0]      id;
    logic [TAGW-1:0] tag;
    logic [OW-1:0]   o;
    logic            ovf;
    logic            unf;
    int              due;
  } exp_t;

  typedef struct {
    logic [1:0]      id;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TAGW-1:0] tag;
    logic [OW-1:0]   o;
    logic            ovf;
    logic            unf;
  } vec_t;

  exp_t            q[$];
  int              ret_log[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              ecyc = 0;
  logic [31:0]     op_a   [NREQ];
  logic [31:0]     op_b   [NREQ];
  logic [TAGW-1:0] op_tag [NREQ];
  logic [1:0]      last_id;
  logic [TAGW-1:0] last_tag;
  logic [OW-1:0]   last_o;
  logic            last_ovf, last_unf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance past posedge.
  task automatic run_cycle(input logic [NREQ-1:0] vld, input logic st,
                           input logic [NREQ-1:0] exp_rdy);
    int   gi;
    exp_t e;
    req_vld = vld;
    stall   = st;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32]       = op_a[i];
      req_b[32*i +: 32]       = op_b[i];
      req_tag[TAGW*i +: TAGW] = op_tag[i];
    end
    #2;
    chk("inflight", 64'(inflight), 64'(q.size()));
    chk("idle", 64'(idle), 64'(q.size() == 0));
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("mul_ce", 64'(mul_ce), 64'(!st));
    if (!st) ecyc++;
    if (!st && q.size() > 0 && q[0].due == ecyc) begin
      chk("res_vld", 64'(res_vld), 64'd1);
      chk("res_id", 64'(res_id), 64'(q[0].id));
      chk("res_tag", 64'(res_tag), 64'(q[0].tag));
      chk("res_o", 64'(res_o), 64'(q[0].o));
      chk("res_ovf", 64'(res_ovf), 64'(q[0].ovf));
      chk("res_unf", 64'(res_unf), 64'(q[0].unf));
      last_id  = res_id;
      last_tag = res_tag;
      last_o   = res_o;
      last_ovf = res_ovf;
      last_unf = res_unf;
      ret_log.push_back(cyc);
      q.delete(0);
    end else begin
      chk("res_vld", 64'(res_vld), 64'd0);
    end
    gi = -1;
    for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) gi = i;
    if (gi >= 0) begin
      chk("mul_a", 64'(mul_a), 64'(op_a[gi]));
      chk("mul_b", 64'(mul_b), 64'(op_b[gi]));
      e.id  = 2'(gi);
      e.tag = op_tag[gi];
      e.o   = {op_a[gi], op_b[gi][25:0]};
      e.ovf = op_a[gi][0];
      e.unf = op_b[gi][0];
      e.due = ecyc + LAT;
      q.push_back(e);
    end else if (vld == '0) begin
      chk("mul_a_bubble", 64'(mul_a), 64'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (gi >= 0) begin
      op_tag[gi] = op_tag[gi] + 1'b1;
      op_a[gi]   = op_a[gi] + 32'h10;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (q.size() > 0 && n < max) begin
      run_cycle('0, 1'b0, '0);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[4];
    int   t0;
    tv[0] = '{2'd2, 32'h40000000, 32'h40400000, 4'h5, {32'h40000000, 26'h0400000}, 1'b0, 1'b0};
    tv[1] = '{2'd0, 32'h3F800001, 32'hBF800000, 4'hA, {32'h3F800001, 26'h3800000}, 1'b1, 1'b0};
    tv[2] = '{2'd3, 32'h7F7FFFFF, 32'h00000001, 4'hF, {32'h7F7FFFFF, 26'h0000001}, 1'b1, 1'b1};
    tv[3] = '{2'd1, 32'h00000000, 32'hFFFFFFFF, 4'h0, {32'h00000000, 26'h3FFFFFF}, 1'b0, 1'b1};

    rst_n = 1'b1; stall = 1'b0; req_vld = '0; req_a = '0; req_b = '0; req_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]   = 32'h3F800000 + 32'(i);
      op_b[i]   = 32'h40000000 + 32'(i * 16);
      op_tag[i] = TAGW'(i);
    end
    #1 rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset state with all requests pending: nothing accepted, idle.
    run_cycle(4'hF, 1'b0, 4'h0);
    run_cycle(4'hF, 1'b0, 4'h0);
    rst_n = 1'b1;

    // Single transactions from the table.
    for (int t = 0; t < 4; t++) begin
      op_a[tv[t].id]   = tv[t].a;
      op_b[tv[t].id]   = tv[t].b;
      op_tag[tv[t].id] = tv[t].tag;
      ret_log.delete();
      t0 = cyc;
      run_cycle(NREQ'(1 << tv[t].id), 1'b0, NREQ'(1 << tv[t].id));
      drain(40);
      chk("tbl_count", 64'(ret_log.size()), 64'd1);
      if (ret_log.size() > 0) chk("tbl_latency", 64'(ret_log[0] - t0), 64'(LAT));
      chk("tbl_id", 64'(last_id), 64'(tv[t].id));
      chk("tbl_tag", 64'(last_tag), 64'(tv[t].tag));
      chk("tbl_o", 64'(last_o), 64'(tv[t].o));
      chk("tbl_ovf", 64'(last_ovf), 64'(tv[t].ovf));
      chk("tbl_unf", 64'(last_unf), 64'(tv[t].unf));
      run_cycle('0, 1'b0, '0);
    end

    // All requesters valid continuously, then requester 0 withdraws.
    for (int k = 0; k < 8; k++) begin
`ifdef FPMUL_ARB_RR_EN
      run_cycle(4'hF, 1'b0, NREQ'(1 << (k % 4)));
`else
      run_cycle(4'hF, 1'b0, 4'b0001);
`endif
    end
    run_cycle(4'b1110, 1'b0, 4'b0010);
    run_cycle(4'b1100, 1'b0, 4'b0100);
    run_cycle(4'b1000, 1'b0, 4'b1000);
    drain(40);

    // Stall: issue on cycles 0..3, stall cycles 6..10 with requests pending.
    ret_log.delete();
    t0 = cyc;
    for (int k = 0; k < 4; k++) run_cycle(NREQ'(1 << k), 1'b0, NREQ'(1 << k));
    run_cycle('0, 1'b0, '0);
    run_cycle('0, 1'b0, '0);
    for (int k = 0; k < 5; k++) run_cycle(4'hF, 1'b1, 4'h0);
    run_cycle(4'hF, 1'b0, 4'b0001);
    drain(40);
    chk("stall_count", 64'(ret_log.size()), 64'd5);
    for (int k = 0; k < 4; k++)
      if (k < ret_log.size()) chk("stall_ret_cycle", 64'(ret_log[k] - t0), 64'(20 + k));

    // Reset mid-flight: six issues, reset at cycle 8 for two clocks.
    for (int k = 0; k < 6; k++) run_cycle(NREQ'(1 << (k % 4)), 1'b0, NREQ'(1 << (k % 4)));
    run_cycle('0, 1'b0, '0);
    run_cycle('0, 1'b0, '0);
    rst_n = 1'b0;
    q.delete();
    run_cycle('0, 1'b0, '0);
    run_cycle('0, 1'b0, '0);
    rst_n = 1'b1;
    ret_log.delete();
    for (int k = 0; k < 30; k++) run_cycle('0, 1'b0, '0);
    chk("rst_discard", 64'(ret_log.size()), 64'd0);
    run_cycle(4'hF, 1'b0, 4'b0001);
    drain(40);
    chk("rst_recover", 64'(ret_log.size()), 64'd1);

    // Back-to-back stream: inflight saturates at LAT, then drains by one per clock.
    for (int k = 0; k < 40; k++) run_cycle(NREQ'(1 << (k % 4)), 1'b0, NREQ'(1 << (k % 4)));
    chk("ss_inflight", 64'(inflight), 64'(LAT));
    drain(40);
    chk("end_idle", 64'(idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
